// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: slices an instruction into typed fields and
// buffers the result in a two-entry (output + skid) valid/ready stage with flush.
module decode_stage #(
  parameter int INSTR_W  = 16,
  parameter int OP_W     = 4,
  parameter int REG_W    = 3,
  parameter int DATA_W   = 16,
  parameter int R_MAX    = 7,
  parameter int I_MAX    = 11,
  parameter int SIGN_EXT = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INSTR_W-1:0]                in_instr,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OP_W-1:0]                   out_opcode,
  output logic [1:0]                        out_type,
  output logic [REG_W-1:0]                  out_rd,
  output logic [REG_W-1:0]                  out_rs,
  output logic [REG_W-1:0]                  out_rt,
  output logic [INSTR_W-OP_W-3*REG_W-1:0]   out_shamt,
  output logic [DATA_W-1:0]                 out_imm,
  output logic [INSTR_W-OP_W-REG_W-1:0]     out_addr,
  output logic                              out_rd_we,
  output logic                              out_rt_used,
  output logic [15:0]                       accepted_cnt
);

  localparam int SH_W   = INSTR_W - OP_W - 3*REG_W;
  localparam int IMM_W  = INSTR_W - OP_W - 2*REG_W;
  localparam int ADDR_W = INSTR_W - OP_W - REG_W;
  localparam logic [OP_W-1:0] L_R_MAX = OP_W'(R_MAX);
  localparam logic [OP_W-1:0] L_I_MAX = OP_W'(I_MAX);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [1:0]        typ;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] addr;
    logic              rd_we;
    logic              rt_used;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  dec_t              r_out;
  dec_t              r_skid;
  dec_t              w_dec;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [15:0]       r_cnt;
  logic [OP_W-1:0]   w_op;
  logic [IMM_W-1:0]  w_imm_raw;
  logic [DATA_W-1:0] w_imm_ext;
  logic              w_acc;
  logic              w_drn;
  logic              w_load_out;
  logic              w_load_skid;
  logic              w_move_skid;
  logic              w_clear;

  assign w_op      = in_instr[INSTR_W-1 -: OP_W];
  assign w_imm_raw = in_instr[IMM_W-1:0];
  assign w_acc     = in_valid & r_in_ready;
  assign w_drn     = r_out_valid & out_ready;

  // Combinational decode; fields not meaningful for the instruction type stay zero.
  always_comb begin
    w_dec = '0;
    if ((SIGN_EXT != 0) && w_imm_raw[IMM_W-1]) begin
      w_imm_ext = {{(DATA_W-IMM_W){1'b1}}, w_imm_raw};
    end else begin
      w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, w_imm_raw};
    end
    w_dec.opcode = w_op;
    if (w_op <= L_R_MAX) begin
      w_dec.typ     = 2'd0;
      w_dec.rd      = in_instr[INSTR_W-OP_W-1 -: REG_W];
      w_dec.rs      = in_instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
      w_dec.rt      = in_instr[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
      w_dec.shamt   = in_instr[SH_W-1:0];
      w_dec.rd_we   = 1'b1;
      w_dec.rt_used = 1'b1;
    end else if (w_op <= L_I_MAX) begin
      w_dec.typ     = 2'd1;
      w_dec.rd      = in_instr[INSTR_W-OP_W-1 -: REG_W];
      w_dec.rs      = in_instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
      w_dec.imm     = w_imm_ext;
      w_dec.rd_we   = 1'b1;
    end else begin
      w_dec.typ     = 2'd2;
      w_dec.addr    = in_instr[INSTR_W-OP_W-1 : REG_W];
    end
  end

  // Storage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control; flush overrides any handshake this cycle.
  always_comb begin
    w_next      = r_state;
    w_load_out  = 1'b0;
    w_load_skid = 1'b0;
    w_move_skid = 1'b0;
    w_clear     = 1'b0;
    if (flush) begin
      w_next  = S_EMPTY;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_next     = S_ONE;
            w_load_out = 1'b1;
          end else begin
            w_next = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_acc && w_drn) begin
            w_next     = S_ONE;
            w_load_out = 1'b1;
          end else if (w_acc) begin
            w_next      = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_drn) begin
            w_next  = S_EMPTY;
            w_clear = 1'b1;
          end else begin
            w_next = S_ONE;
          end
        end
        S_FULL: begin
          if (w_drn) begin
            w_next      = S_ONE;
            w_move_skid = 1'b1;
          end else begin
            w_next = S_FULL;
          end
        end
        default: begin
          w_next  = S_EMPTY;
          w_clear = 1'b1;
        end
      endcase
    end
  end

  // Output/skid registers, registered handshake flags and the accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= 16'd0;
    end else begin
      if (w_clear) begin
        r_out  <= '0;
        r_skid <= '0;
      end else if (w_load_out) begin
        r_out <= w_dec;
      end else if (w_move_skid) begin
        r_out  <= r_skid;
        r_skid <= '0;
      end else if (w_load_skid) begin
        r_skid <= w_dec;
      end
      r_in_ready  <= (w_next != S_FULL);
      r_out_valid <= (w_next != S_EMPTY);
      if (w_acc && !flush) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_opcode   = r_out.opcode;
  assign out_type     = r_out.typ;
  assign out_rd       = r_out.rd;
  assign out_rs       = r_out.rs;
  assign out_rt       = r_out.rt;
  assign out_shamt    = r_out.shamt;
  assign out_imm      = r_out.imm;
  assign out_addr     = r_out.addr;
  assign out_rd_we    = r_out.rd_we;
  assign out_rt_used  = r_out.rt_used;
  assign accepted_cnt = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed and random stimulus against a queue-based
// model; a second instance with zero-extension shares the same inputs.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0000;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_rd_we, out_rt_used;
  logic [3:0]  out_opcode;
  logic [1:0]  out_type;
  logic [2:0]  out_rd, out_rs, out_rt, out_shamt;
  logic [15:0] out_imm, accepted_cnt;
  logic [8:0]  out_addr;

  logic        z_in_ready, z_out_valid, z_rd_we, z_rt_used;
  logic [3:0]  z_opcode;
  logic [1:0]  z_type;
  logic [2:0]  z_rd, z_rs, z_rt, z_shamt;
  logic [15:0] z_imm, z_cnt;
  logic [8:0]  z_addr;

  int checks = 0;
  int failures = 0;
  int q[$];
  logic [15:0] m_cnt = 16'd0;

  typedef struct {
    int op; int typ; int rd; int rs; int rt; int sh;
    int imm_s; int imm_z; int addr; int we; int rtu;
  } exp_t;

  always #5 clk = ~clk;

  decode_stage #(.SIGN_EXT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_type(out_type), .out_rd(out_rd), .out_rs(out_rs),
    .out_rt(out_rt), .out_shamt(out_shamt), .out_imm(out_imm), .out_addr(out_addr),
    .out_rd_we(out_rd_we), .out_rt_used(out_rt_used), .accepted_cnt(accepted_cnt)
  );

  decode_stage #(.SIGN_EXT(0)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_opcode(z_opcode), .out_type(z_type), .out_rd(z_rd), .out_rs(z_rs),
    .out_rt(z_rt), .out_shamt(z_shamt), .out_imm(z_imm), .out_addr(z_addr),
    .out_rd_we(z_rd_we), .out_rt_used(z_rt_used), .accepted_cnt(z_cnt)
  );

  function automatic exp_t model(input int instr, input bit present);
    exp_t e;
    int raw;
    e.op = 0; e.typ = 0; e.rd = 0; e.rs = 0; e.rt = 0; e.sh = 0;
    e.imm_s = 0; e.imm_z = 0; e.addr = 0; e.we = 0; e.rtu = 0;
    if (present) begin
      e.op = instr / 4096;
      if (e.op <= 7) begin
        e.typ = 0; e.rd = (instr / 512) % 8; e.rs = (instr / 64) % 8;
        e.rt = (instr / 8) % 8; e.sh = instr % 8; e.we = 1; e.rtu = 1;
      end else if (e.op <= 11) begin
        raw = instr % 64;
        e.typ = 1; e.rd = (instr / 512) % 8; e.rs = (instr / 64) % 8; e.we = 1;
        e.imm_z = raw;
        e.imm_s = (raw >= 32) ? raw + 65536 - 64 : raw;
      end else begin
        e.typ = 2; e.addr = (instr / 8) % 512;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string t);
    exp_t e;
    bit   present;
    present = (q.size() > 0);
    e = model(present ? q[0] : 0, present);
    chk({t, ":out_valid"}, 32'(out_valid), 32'(present));
    chk({t, ":in_ready"},  32'(in_ready), 32'(q.size() < 2));
    chk({t, ":opcode"},    32'(out_opcode), e.op);
    chk({t, ":type"},      32'(out_type), e.typ);
    chk({t, ":rd"},        32'(out_rd), e.rd);
    chk({t, ":rs"},        32'(out_rs), e.rs);
    chk({t, ":rt"},        32'(out_rt), e.rt);
    chk({t, ":shamt"},     32'(out_shamt), e.sh);
    chk({t, ":imm"},       32'(out_imm), e.imm_s);
    chk({t, ":addr"},      32'(out_addr), e.addr);
    chk({t, ":rd_we"},     32'(out_rd_we), e.we);
    chk({t, ":rt_used"},   32'(out_rt_used), e.rtu);
    chk({t, ":cnt"},       32'(accepted_cnt), 32'(m_cnt));
    chk({t, ":z_valid"},   32'(z_out_valid), 32'(present));
    chk({t, ":z_imm"},     32'(z_imm), e.imm_z);
  endtask

  // One cycle: drive at the falling edge, check current outputs, then advance the model.
  task automatic step(input bit v, input logic [15:0] ins, input bit rdy, input bit fl);
    bit acc, drn;
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
    check_all("step");
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(int'(ins));
        m_cnt = m_cnt + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 16'd0;
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] cnt_before;
    @(negedge clk);
    check_all("reset_hi");
    @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Directed decode stream with out_ready high.
    step(1'b1, 16'h1A53, 1'b1, 1'b0);
    chk("R_type", 32'(out_type), 32'd0);
    chk("R_rd", 32'(out_rd), 32'd5);
    chk("R_rs", 32'(out_rs), 32'd1);
    chk("R_rt", 32'(out_rt), 32'd2);
    chk("R_shamt", 32'(out_shamt), 32'd3);
    step(1'b1, 16'h9A45, 1'b1, 1'b0);
    chk("I_type", 32'(out_type), 32'd1);
    chk("I_imm", 32'(out_imm), 32'h0005);
    chk("I_rt", 32'(out_rt), 32'd0);
    step(1'b1, 16'hC1F8, 1'b1, 1'b0);
    chk("J_type", 32'(out_type), 32'd2);
    chk("J_addr", 32'(out_addr), 32'h03F);
    chk("J_rd_we", 32'(out_rd_we), 32'd0);
    step(1'b1, 16'h8A7F, 1'b1, 1'b0);
    chk("I_imm_sext", 32'(out_imm), 32'hFFFF);
    chk("I_imm_zext", 32'(z_imm), 32'h003F);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Back-pressure: three offers, two accepted, held stable, then drained in order.
    step(1'b1, 16'h2B6D, 1'b0, 1'b0);
    step(1'b1, 16'hA1C3, 1'b0, 1'b0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'hE777, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush while full with an offer present, then flush in ONE with an acceptable offer.
    step(1'b1, 16'h3456, 1'b0, 1'b0);
    step(1'b1, 16'h9ABC, 1'b0, 1'b0);
    cnt_before = m_cnt;
    step(1'b1, 16'hF00F, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_cnt", 32'(accepted_cnt), 32'(cnt_before));
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    cnt_before = m_cnt;
    step(1'b1, 16'h2222, 1'b1, 1'b1);
    chk("flush_one_cnt", 32'(accepted_cnt), 32'(cnt_before));

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    end

    // Counter wrap: exactly 65536 accepts from a fresh reset.
    mid_reset();
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, 16'($urandom), 1'b1, 1'b0);
    end
    chk("cnt_wrap", 32'(accepted_cnt), 32'd0);
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage. It sits between instruction fetch and register read. It splits each instruction into opcode, type, register indices, shift amount, extended immediate and jump address. Both ports use a valid/ready handshake, and a two-entry skid buffer lets the stage sustain one instruction per cycle under back-pressure. Unused fields are driven to zero, never held, and a synchronous flush discards in-flight instructions on branches.

## Interface
- INSTR_W, 16, instruction width
- OP_W, 4, opcode width (instr[INSTR_W-1 -: OP_W])
- REG_W, 3, register-index width
- DATA_W, 16, width of extended immediate output (DATA_W ≥ INSTR_W-OP_W-2*REG_W)
- R_MAX, 7, opcodes 0..R_MAX are R-type
- I_MAX, 11, opcodes R_MAX+1..I_MAX are I-type; above I_MAX are J-type
- SIGN_EXT, 1, 1 = sign-extend immediate, 0 = zero-extend
- Derived widths: SH_W = INSTR_W-OP_W-3*REG_W (3); IMM_W = INSTR_W-OP_W-2*REG_W (6); ADDR_W = INSTR_W-OP_W-REG_W (9)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discard all buffered instructions
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept this cycle
- in_instr  in  INSTR_W  instruction word
- out_valid  out  1  decoded instruction present
- out_ready  in  1  downstream accepts this cycle
- out_opcode  out  OP_W  opcode
- out_type  out  2  0=R, 1=I, 2=J (3 never produced)
- out_rd, out_rs, out_rt  out  REG_W each  register indices
- out_shamt  out  SH_W  shift amount
- out_imm  out  DATA_W  extended immediate
- out_addr  out  ADDR_W  jump address
- out_rd_we  out  1  destination written (R and I types)
- out_rt_used  out  1  rt read (R type only)
- accepted_cnt  out  16  accepted-instruction counter, wraps at 2^16

## Operation
- Field slicing, MSB first: opcode; rd = next REG_W bits; rs = next REG_W; rt = next REG_W; shamt = low SH_W bits; imm = low IMM_W bits; addr = instr[INSTR_W-OP_W-1 : REG_W].
- Per type, unused fields are 0:
  - R: rd, rs, rt, shamt valid; imm = 0, addr = 0.
  - I: rd, rs, imm valid; rt = 0, shamt = 0, addr = 0.
  - J: addr valid; rd = rs = rt = shamt = imm = 0; rd_we = 0.
- Immediate: when SIGN_EXT = 1, bit IMM_W-1 is replicated up to DATA_W; otherwise upper bits are 0.
- Decode is combinational on in_instr; the result is stored whole into the output register or the skid register.
- Storage states:
  - EMPTY: out_valid = 0.
  - ONE: output register valid, skid empty.
  - FULL: both valid.
- Transitions, with acc = in_valid & in_ready and drn = out_valid & out_ready:
  - EMPTY + acc → ONE.
  - ONE + acc + drn → ONE, output register reloaded.
  - ONE + acc + !drn → FULL, new instruction into skid.
  - ONE + !acc + drn → EMPTY.
  - FULL + drn → ONE, skid moves to output register.
- in_ready = (state != FULL). It is registered: it deasserts the cycle after entering FULL and reasserts the cycle after leaving FULL.
- flush has priority over everything else. Next state is EMPTY, acc in the same cycle is ignored and does not increment the counter, and in_ready = 1 the next cycle.
- accepted_cnt increments on every acc that is not flushed.
- Decoded outputs in EMPTY are don't-care but are held at 0.

## Timing
- Reset (async assert, sync-released on clk): out_valid = 0, in_ready = 1, all decoded outputs = 0, accepted_cnt = 0, state EMPTY.
- Latency: an instruction accepted on edge N appears with out_valid = 1 after edge N.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Output fields are stable while out_valid & !out_ready (no change without a handshake).
- No combinational path from out_ready to in_ready.
- Reset asserted mid-stream clears both entries immediately; instructions in flight are lost.

## Test plan
- Stream 0x1A53 (R), 0x9A45 (I), 0xC1F8 (J) with out_ready = 1 → one per cycle after 1-cycle latency:
  - R: type 0, rd 5, rs 1, rt 2, shamt 3.
  - I: type 1, rd 5, rs 1, imm 0x0005, rt 0.
  - J: type 2, addr 0x03F, rd_we 0, other fields 0.
- I-type 0x8A7F with SIGN_EXT = 1 → imm 0xFFFF; with SIGN_EXT = 0 → imm 0x003F.
- out_ready = 0 while 3 instructions are offered → first two held (FULL), in_ready = 0 from the cycle after the second accept, outputs stable. Release out_ready → instructions emerge in order, no loss or duplication.
- flush asserted in FULL with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, accepted_cnt unchanged by the flushed-cycle offer.
- Reset asserted mid-stream between clock edges → all outputs zero and out_valid = 0 immediately; accepted_cnt = 0.
- 65536 accepted instructions → accepted_cnt wraps to 0.
